// File: rtl/osc_mon_pkg.sv
// osc_mon_pkg: shared FSM state, count type and 27 MHz / (div-64 oscillator) defaults
package osc_mon_pkg;
   localparam int DEF_CLK_HZ      = 27_000_000;
   localparam int DEF_OSC_HZ      = 52_480_000;
   localparam int DEF_OSC_DIV     = 64;
   localparam int DEF_GATE_CYCLES = DEF_CLK_HZ / 1000;
   localparam int DEF_EXP_NOM     = DEF_OSC_HZ / DEF_OSC_DIV / 1000;
   localparam int DEF_EXP_MIN     = DEF_EXP_NOM - 40;
   localparam int DEF_EXP_MAX     = DEF_EXP_NOM + 40;
   localparam int DEF_DEAD_CYCLES = 1023;
   localparam int DEF_CNT_W       = 16;
   typedef logic [DEF_CNT_W-1:0] count_t;
   typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings an asynchronous level into clk and emits a one-cycle rising-edge pulse
module sync_edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic rise_o
);
   logic meta_q, sync_q, hist_q;
   // two synchroniser stages followed by a history stage for edge detection
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) {meta_q, sync_q, hist_q} <= '0;
      else {meta_q, sync_q, hist_q} <= {async_i, meta_q, sync_q};
   assign rise_o = sync_q & ~hist_q;
endmodule

// File: rtl/osc_freq_monitor.sv
// osc_freq_monitor: counts osc_div rising edges over a clk gate window, reports range and dead status
module osc_freq_monitor
   import osc_mon_pkg::*;
#(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int EXP_MIN     = DEF_EXP_MIN,
   parameter int EXP_MAX     = DEF_EXP_MAX,
   parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             osc_div,
   output logic [CNT_W-1:0] freq_count,
   output logic             meas_valid,
   output logic             freq_ok,
   output logic             osc_dead,
   output logic             busy
);
   localparam int GW = $clog2(GATE_CYCLES + 1);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   state_e           state_q, state_d;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, freq_count_q, freq_count_d;
   logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
   logic             meas_valid_q, meas_valid_d, freq_ok_q, freq_ok_d;
   logic             rise, in_range;

   sync_edge_det u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (osc_div),
      .rise_o  (rise)
   );

   assign in_range   = edge_cnt_q >= CNT_W'(EXP_MIN) && edge_cnt_q <= CNT_W'(EXP_MAX);
   assign osc_dead   = dead_cnt_q == DW'(DEAD_CYCLES);
   assign busy       = state_q != IDLE;
   assign freq_count = freq_count_q;
   assign meas_valid = meas_valid_q;
   assign freq_ok    = freq_ok_q;

   // gate FSM: window counting, saturating edge count and end-of-window report
   always_comb begin
      state_d      = state_q;
      gate_cnt_d   = gate_cnt_q;
      edge_cnt_d   = edge_cnt_q;
      freq_count_d = freq_count_q;
      freq_ok_d    = freq_ok_q;
      meas_valid_d = 1'b0;
      case (state_q)
         IDLE: if (enable) begin
            state_d    = MEASURE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
         end
         MEASURE: begin
            gate_cnt_d = gate_cnt_q + GW'(1);
            edge_cnt_d = (rise && !(&edge_cnt_q)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
            state_d    = !enable ? IDLE : (gate_cnt_q == GW'(GATE_CYCLES - 1)) ? REPORT : MEASURE;
         end
         REPORT: begin
            freq_count_d = edge_cnt_q;
            freq_ok_d    = in_range && !osc_dead;
            meas_valid_d = 1'b1;
            gate_cnt_d   = '0;
            edge_cnt_d   = '0;
            state_d      = enable ? MEASURE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // watchdog: restarts on every rise, otherwise climbs and parks at the dead threshold
   always_comb dead_cnt_d = rise ? '0 : osc_dead ? dead_cnt_q : dead_cnt_q + DW'(1);

   // state and result registers
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q      <= IDLE;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         freq_count_q <= '0;
         freq_ok_q    <= 1'b0;
         meas_valid_q <= 1'b0;
         dead_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         gate_cnt_q   <= gate_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         freq_count_q <= freq_count_d;
         freq_ok_q    <= freq_ok_d;
         meas_valid_q <= meas_valid_d;
         dead_cnt_q   <= dead_cnt_d;
      end

   // an inverted acceptance range can never report ok
   a_exp_order: assert property (@(posedge clk) EXP_MIN <= EXP_MAX)
      else $error("osc_freq_monitor: EXP_MIN exceeds EXP_MAX");
endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb_osc_freq_monitor: scoreboard bench with a scaled-down gate window and an 8-bit saturation instance
module tb_osc_freq_monitor;
   import osc_mon_pkg::*;
   localparam int GATE = 600;
   localparam int EMIN = 20;
   localparam int EMAX = 30;
   localparam int DEAD = 100;

   typedef struct {
      int cnt;
      bit ok;
   } exp_t;

   logic        clk, reset_n, enable, osc, enable_s, osc_fast;
   logic [15:0] freq_count;
   logic [7:0]  freq_count_s;
   logic        meas_valid, freq_ok, osc_dead, busy;
   logic        mv_s, ok_s, dead_s, busy_s;
   int          cyc = 0, n_chk = 0, n_pass = 0;
   exp_t        sb[$];

   osc_freq_monitor #(.GATE_CYCLES(GATE), .CNT_W(16), .EXP_MIN(EMIN), .EXP_MAX(EMAX), .DEAD_CYCLES(DEAD)) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .osc_div(osc),
      .freq_count(freq_count), .meas_valid(meas_valid), .freq_ok(freq_ok), .osc_dead(osc_dead), .busy(busy)
   );

   osc_freq_monitor #(.GATE_CYCLES(GATE), .CNT_W(8), .EXP_MIN(EMIN), .EXP_MAX(EMAX), .DEAD_CYCLES(DEAD)) u_sat (
      .clk(clk), .reset_n(reset_n), .enable(enable_s), .osc_div(osc_fast),
      .freq_count(freq_count_s), .meas_valid(mv_s), .freq_ok(ok_s), .osc_dead(dead_s), .busy(busy_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      osc_fast = 1'b0;
      forever @(negedge clk) osc_fast = ~osc_fast;
   end

   // n evenly spaced rising edges, starting 10 cycles into the window and finishing well before its end
   task automatic gen_pulses(input int n);
      int s;
      s = 560 / n;
      repeat (10) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         osc = 1'b1;
         repeat (2) @(negedge clk);
         osc = 1'b0;
         repeat (s - 2) @(negedge clk);
      end
   endtask

   task automatic wait_strobe(input bit sat, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         got = sat ? mv_s : meas_valid;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; enable_s = 1'b0; osc = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (freq_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", freq_count); else n_pass++;
      n_chk++; if (meas_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", meas_valid); else n_pass++;
      n_chk++; if (freq_ok !== 1'b0) $display("FAIL rst_ok: got %b want 0", freq_ok); else n_pass++;
      n_chk++; if (osc_dead !== 1'b0) $display("FAIL rst_dead: got %b want 0", osc_dead); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_in_range();
      int   tbl[6] = '{25, 35, 20, 30, 31, 19};
      int   t_prev;
      bit   got;
      exp_t e;
      enable = 1'b1;
      t_prev = cyc;
      for (int i = 0; i < 6; i++) begin
         sb.push_back(exp_t'{tbl[i], tbl[i] >= EMIN && tbl[i] <= EMAX});
         gen_pulses(tbl[i]);
         n_chk++; if (busy !== 1'b1) $display("FAIL busy_mid[%0d]: got %b want 1", i, busy); else n_pass++;
         wait_strobe(1'b0, 100, got);
         e = sb.pop_front();
         n_chk++; if (!got) $display("FAIL strobe_timeout[%0d]: got none want strobe", i); else n_pass++;
         n_chk++; if (freq_count !== 16'(e.cnt)) $display("FAIL count[%0d]: got %0d want %0d", i, freq_count, e.cnt); else n_pass++;
         n_chk++; if (freq_ok !== e.ok) $display("FAIL ok[%0d]: got %b want %b", i, freq_ok, e.ok); else n_pass++;
         n_chk++; if (cyc - t_prev != (i == 0 ? GATE + 2 : GATE + 1)) $display("FAIL spacing[%0d]: got %0d", i, cyc - t_prev); else n_pass++;
         t_prev = cyc;
      end
   endtask

   task automatic test_dead();
      int   n;
      bit   got;
      exp_t e;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 24; i++) begin
         osc = 1'b1;
         repeat (2) @(negedge clk);
         osc = 1'b0;
         repeat (2) @(negedge clk);
      end
      sb.push_back(exp_t'{25, 1'b0});
      osc = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 2) osc = 1'b0;
      end while (!osc_dead && n < 300);
      n_chk++; if (n != DEAD + 3) $display("FAIL dead_latency: got %0d want %0d", n, DEAD + 3); else n_pass++;
      wait_strobe(1'b0, 700, got);
      e = sb.pop_front();
      n_chk++; if (!got) $display("FAIL dead_strobe_timeout: got none want strobe"); else n_pass++;
      n_chk++; if (freq_count !== 16'(e.cnt)) $display("FAIL dead_count: got %0d want %0d", freq_count, e.cnt); else n_pass++;
      n_chk++; if (freq_ok !== e.ok) $display("FAIL dead_ok: got %b want %b", freq_ok, e.ok); else n_pass++;
      n_chk++; if (osc_dead !== 1'b1) $display("FAIL dead_hold: got %b want 1", osc_dead); else n_pass++;
      osc = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 2) osc = 1'b0;
      end while (osc_dead && n < 20);
      n_chk++; if (n != 3) $display("FAIL dead_recover: got %0d want 3", n); else n_pass++;
      sb.push_back(exp_t'{25, 1'b1});
      gen_pulses(24);
      wait_strobe(1'b0, 100, got);
      e = sb.pop_front();
      n_chk++; if (!got) $display("FAIL recov_strobe_timeout: got none want strobe"); else n_pass++;
      n_chk++; if (freq_count !== 16'(e.cnt)) $display("FAIL recov_count: got %0d want %0d", freq_count, e.cnt); else n_pass++;
      n_chk++; if (freq_ok !== e.ok) $display("FAIL recov_ok: got %b want %b", freq_ok, e.ok); else n_pass++;
   endtask

   task automatic test_abort();
      count_t held;
      int     strobes, c0;
      bit     got;
      exp_t   e;
      held = freq_count;
      repeat (300) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
      strobes = 0;
      repeat (700) begin
         @(negedge clk);
         if (meas_valid) strobes++;
      end
      n_chk++; if (strobes != 0) $display("FAIL abort_strobe: got %0d want 0", strobes); else n_pass++;
      n_chk++; if (freq_count !== 16'd25) $display("FAIL abort_count_hold: got %0d want 25 (was %0d)", freq_count, held); else n_pass++;
      n_chk++; if (freq_ok !== 1'b1) $display("FAIL abort_ok_hold: got %b want 1", freq_ok); else n_pass++;
      enable = 1'b1;
      c0 = cyc;
      sb.push_back(exp_t'{22, 1'b1});
      gen_pulses(22);
      wait_strobe(1'b0, 100, got);
      e = sb.pop_front();
      n_chk++; if (!got) $display("FAIL reen_strobe_timeout: got none want strobe"); else n_pass++;
      n_chk++; if (cyc - c0 != GATE + 2) $display("FAIL reen_latency: got %0d want %0d", cyc - c0, GATE + 2); else n_pass++;
      n_chk++; if (freq_count !== 16'(e.cnt)) $display("FAIL reen_count: got %0d want %0d", freq_count, e.cnt); else n_pass++;
      n_chk++; if (freq_ok !== e.ok) $display("FAIL reen_ok: got %b want %b", freq_ok, e.ok); else n_pass++;
   endtask

   task automatic test_async_reset();
      int   c0;
      bit   got;
      exp_t e;
      repeat (200) @(negedge clk);
      n_chk++; if (busy !== 1'b1 || freq_count !== 16'd22) $display("FAIL pre_reset: got busy %b count %0d want 1 22", busy, freq_count); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_chk++; if (freq_count !== 16'd0 || freq_ok !== 1'b0) $display("FAIL async_rst_result: got %0d %b want 0 0", freq_count, freq_ok); else n_pass++;
      n_chk++; if (busy !== 1'b0 || meas_valid !== 1'b0 || osc_dead !== 1'b0) $display("FAIL async_rst_flags: got %b%b%b want 000", busy, meas_valid, osc_dead); else n_pass++;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      c0 = cyc;
      sb.push_back(exp_t'{27, 1'b1});
      gen_pulses(27);
      wait_strobe(1'b0, 100, got);
      e = sb.pop_front();
      n_chk++; if (!got) $display("FAIL post_rst_timeout: got none want strobe"); else n_pass++;
      n_chk++; if (cyc - c0 != GATE + 2) $display("FAIL post_rst_latency: got %0d want %0d", cyc - c0, GATE + 2); else n_pass++;
      n_chk++; if (freq_count !== 16'(e.cnt)) $display("FAIL post_rst_count: got %0d want %0d", freq_count, e.cnt); else n_pass++;
      n_chk++; if (freq_ok !== e.ok) $display("FAIL post_rst_ok: got %b want %b", freq_ok, e.ok); else n_pass++;
   endtask

   task automatic test_saturate();
      bit   got;
      exp_t e;
      enable_s = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(exp_t'{255, 1'b0});
         wait_strobe(1'b1, 700, got);
         e = sb.pop_front();
         n_chk++; if (!got) $display("FAIL sat_timeout[%0d]: got none want strobe", i); else n_pass++;
         n_chk++; if (freq_count_s !== 8'(e.cnt)) $display("FAIL sat_count[%0d]: got %0d want %0d", i, freq_count_s, e.cnt); else n_pass++;
         n_chk++; if (ok_s !== e.ok) $display("FAIL sat_ok[%0d]: got %b want %b", i, ok_s, e.ok); else n_pass++;
         n_chk++; if (dead_s !== 1'b0 || busy_s !== 1'b1) $display("FAIL sat_flags[%0d]: got dead %b busy %b want 0 1", i, dead_s, busy_s); else n_pass++;
      end
      n_chk++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_in_range();
      test_dead();
      test_abort();
      test_async_reset();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
